// File: rtl/jtcps1_obj_pkg.sv
// Shared definitions for the CPS1 object frame-table controller.
package jtcps1_obj_pkg;

   localparam int unsigned OBJ_WORDS = 1024;
   localparam logic [7:0]  END_MARK  = 8'hFF;
   localparam logic [15:0] FILL_WORD = 16'hFFFF;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StWr,
      StFill,
      StDone
   } obj_st_e;

endpackage

// File: rtl/jtcps1_obj_table_ctrl_if.sv
// VRAM read bus between the object table controller and the video memory.
interface jtcps1_obj_table_ctrl_if;

   logic [16:0] vram_addr;
   logic        vram_cs;
   logic [15:0] vram_data;
   logic        vram_ok;

   modport master (
      output vram_addr,
      output vram_cs,
      input  vram_data,
      input  vram_ok
   );

   modport slave (
      input  vram_addr,
      input  vram_cs,
      output vram_data,
      output vram_ok
   );

endinterface

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: port A writes, port B registered reads.
module jtframe_dual_ram #(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] data_a,
   input  logic [AW-1:0] addr_a,
   input  logic          we_a,
   input  logic [AW-1:0] addr_b,
   output logic [DW-1:0] q_b
);

   localparam int unsigned Depth = 1 << AW;

   logic [DW-1:0] mem [Depth];

   // Port A write; contents are not reset
   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= data_a;
   end

   // Port B registered read, cleared by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_b <= '0;
      else     q_b <= mem[addr_b];
   end

endmodule

// File: rtl/jtcps1_obj_table_ctrl.sv
// Double-buffered object frame table: copies the VRAM object list into the
// back bank every vblank, swaps banks on the following vblank, serves the
// scanner from the front bank and issues the per-line start pulse.
// Optional feature: define JTCPS1_OBJ_ENDMARK_EN to stop copying after an
// end-marker entry and fill the rest of the table with 16'hFFFF.
module jtcps1_obj_table_ctrl #(
   parameter int unsigned OBJ_WORDS = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       vblank,
   input  logic                       hs,
   input  logic [6:0]                 vram_base,
   jtcps1_obj_table_ctrl_if.master    vram,
   input  logic [9:0]                 frame_addr,
   output logic [15:0]                frame_data,
   output logic                       line_start,
   output logic                       busy,
   output logic                       copy_overrun
);

   import jtcps1_obj_pkg::*;

   localparam logic [9:0] LastIdx = 10'(OBJ_WORDS - 1);

   obj_st_e     state_q, state_d;
   logic [9:0]  idx_q, idx_d;
   logic [16:0] addr_q, addr_d;
   logic [15:0] data_q;
   logic        bank_q, bank_d;
   logic        pending_q, pending_d;
   logic        overrun_q, overrun_d;
   logic        abort_q, abort_d;

   logic        hs_q, hs_qq, vb_q, vb_qq;
   logic        hs_rise, vb_rise;
   logic        we;
   logic [15:0] wr_data;

   assign hs_rise = hs_q & ~hs_qq;
   assign vb_rise = vb_q & ~vb_qq;

   // Registered edge detectors and the line start pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_q       <= 1'b0;
         hs_qq      <= 1'b0;
         vb_q       <= 1'b0;
         vb_qq      <= 1'b0;
         line_start <= 1'b0;
      end else begin
         hs_q       <= hs;
         hs_qq      <= hs_q;
         vb_q       <= vblank;
         vb_qq      <= vb_q;
         line_start <= hs_rise;
      end
   end

   // Copy engine state and bank bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         bank_q    <= 1'b0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         bank_q    <= bank_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         abort_q   <= abort_d;
         if (state_q == StWait && vram.vram_ok) data_q <= vram.vram_data;
      end
   end

   // Next-state logic; a vblank rising edge overrides the running copy
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      bank_d    = bank_q;
      pending_d = pending_q;
      overrun_d = overrun_q;
      abort_d   = 1'b0;
      we        = 1'b0;
      wr_data   = data_q;

      case (state_q)
         StIdle: ;
         // after an abort, REQ spends one cycle with cs low before re-requesting
         StReq:  if (!abort_q) state_d = StWait;
         StWait: if (vram.vram_ok) state_d = StWr;
         StWr: begin
            we = 1'b1;
            if (idx_q == LastIdx) begin
               state_d = StDone;
            end
`ifdef JTCPS1_OBJ_ENDMARK_EN
            else if (idx_q[1:0] == 2'd3 && data_q[15:8] == END_MARK) begin
               state_d = StFill;
               idx_d   = idx_q + 10'd1;
            end
`endif
            else begin
               state_d = StReq;
               idx_d   = idx_q + 10'd1;
               addr_d  = {vram_base, idx_q + 10'd1};
            end
         end
         StFill: begin
            we      = 1'b1;
            wr_data = FILL_WORD;
            if (idx_q == LastIdx) state_d = StDone;
            else                  idx_d   = idx_q + 10'd1;
         end
         StDone: begin
            pending_d = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (vb_rise) begin
         if (state_q == StIdle) begin
            if (pending_q) begin
               bank_d    = ~bank_q;
               pending_d = 1'b0;
               overrun_d = 1'b0;
            end
         end else begin
            pending_d = pending_q;
            overrun_d = 1'b1;
            abort_d   = 1'b1;
         end
         state_d = StReq;
         idx_d   = '0;
         addr_d  = {vram_base, 10'd0};
      end
   end

   assign vram.vram_cs   = (state_q == StReq && !abort_q) || state_q == StWait;
   assign vram.vram_addr = addr_q;
   assign busy           = state_q != StIdle;
   assign copy_overrun   = overrun_q;

   jtframe_dual_ram #(
      .DW (16),
      .AW (11)
   ) u_ram (
      .clk    (clk),
      .rst    (rst),
      .data_a (wr_data),
      .addr_a ({~bank_q, idx_q}),
      .we_a   (we),
      .addr_b ({bank_q, frame_addr}),
      .q_b    (frame_data)
   );

endmodule

// File: tb/tb_jtcps1_obj_table_ctrl.sv
// Scoreboard bench for jtcps1_obj_table_ctrl: expected VRAM requests, frame
// reads and line pulses are queued by the stimulus and checked by a monitor.
module tb_jtcps1_obj_table_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vblank = 1'b0;
   logic        hs = 1'b0;
   logic [6:0]  vram_base = '0;
   logic [9:0]  frame_addr = '0;
   logic [15:0] frame_data;
   logic        line_start, busy, copy_overrun;

   jtcps1_obj_table_ctrl_if vif ();

   jtcps1_obj_table_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .vblank       (vblank),
      .hs           (hs),
      .vram_base    (vram_base),
      .vram         (vif),
      .frame_addr   (frame_addr),
      .frame_data   (frame_data),
      .line_start   (line_start),
      .busy         (busy),
      .copy_overrun (copy_overrun)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // VRAM model: data valid one cycle after the request is seen
   logic ok_en = 1'b0;
   logic endmark_on = 1'b0;

   function automatic logic [15:0] vdata(input logic [16:0] a);
      vdata = {1'b0, a[14:0]} ^ 16'h1234;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         vif.vram_ok   <= 1'b0;
         vif.vram_data <= '0;
      end else begin
         vif.vram_ok   <= vif.vram_cs && ok_en && !vif.vram_ok;
         vif.vram_data <= (endmark_on && vif.vram_addr[9:0] == 10'd11) ? 16'hFF00
                                                                       : vdata(vif.vram_addr);
      end
   end

   // Scoreboards
   logic [16:0] aq[$];
   logic [15:0] rq[$];
   int unsigned lq[$];

   logic        prev_cs = 1'b0;
   logic [16:0] last_addr = '0;
   logic        rd_req = 1'b0;
   logic        rd_stage = 1'b0;

   always @(posedge clk) rd_stage <= rd_req;

   // Monitor
   always @(negedge clk) begin
      if (vif.vram_cs && !prev_cs) begin
         if (aq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL vram unexpected request: addr %0h", vif.vram_addr);
         end else begin
            check("vram addr", {15'd0, vif.vram_addr}, {15'd0, aq.pop_front()});
         end
      end else if (vif.vram_cs) begin
         check("vram addr stable", {15'd0, vif.vram_addr}, {15'd0, last_addr});
      end
      prev_cs   <= vif.vram_cs;
      last_addr <= vif.vram_addr;
      if (rd_stage) begin
         if (rq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL frame read with no expectation");
         end else begin
            check("frame_data", {16'd0, frame_data}, {16'd0, rq.pop_front()});
         end
      end
      if (line_start) begin
         if (lq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL line_start unexpected at cycle %0d", cyc);
         end else begin
            check("line_start cycle", cyc, lq.pop_front());
         end
      end
   end

   // hs generator: rises every 128 cycles, pulse expected 2 cycles later
   logic hs_run = 1'b0;
   initial begin
      wait (hs_run);
      while (hs_run) begin
         @(posedge clk);
         #1;
         if (cyc % 128 == 64) begin
            hs = 1'b1;
            if (!rst) lq.push_back(cyc + 2);
         end else if (cyc % 128 == 0) begin
            hs = 1'b0;
         end
      end
   end

   task automatic push_copy(input logic [6:0] base, input int first, input int last);
      for (int i = first; i <= last; i++) aq.push_back({base, 10'(i)});
   endtask

   task automatic vb_pulse();
      @(posedge clk);
      #1 vblank = 1'b1;
      repeat (3) @(posedge clk);
      #1 vblank = 1'b0;
   endtask

   task automatic rd(input logic [9:0] a, input logic [15:0] exp);
      @(posedge clk);
      #1;
      frame_addr = a;
      rd_req     = 1'b1;
      rq.push_back(exp);
      @(posedge clk);
      #1 rd_req = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while (busy && n < 6000) begin
         @(negedge clk);
         n++;
      end
      check({"copy completes ", name}, {31'd0, busy}, 32'd0);
      check({"all requests seen ", name}, aq.size(), 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset vram_cs", {31'd0, vif.vram_cs}, 32'd0);
      check("reset vram_addr", {15'd0, vif.vram_addr}, 32'd0);
      check("reset line_start", {31'd0, line_start}, 32'd0);
      check("reset overrun", {31'd0, copy_overrun}, 32'd0);
      check("reset frame_data", {16'd0, frame_data}, 32'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      hs_run = 1'b1;

      // First copy into back bank 1
      vram_base = 7'h15;
      ok_en     = 1'b1;
      push_copy(7'h15, 0, 1023);
      vb_pulse();
      @(negedge clk);
      check("busy during copy1", {31'd0, busy}, 32'd1);
      wait_idle("copy1");
      check("no overrun copy1", {31'd0, copy_overrun}, 32'd0);

      // Swap: copy1 becomes visible, copy2 starts
      vram_base = 7'h2A;
      push_copy(7'h2A, 0, 1023);
      vb_pulse();
      rd(10'd5, vdata({7'h15, 10'd5}));
      rd(10'd0, vdata({7'h15, 10'd0}));
      rd(10'd1023, vdata({7'h15, 10'd1023}));
      @(negedge clk);
      check("busy during copy2", {31'd0, busy}, 32'd1);
      wait_idle("copy2");

      // Overrun: copy3 stalls in WAIT, next vblank aborts and restarts it
      ok_en     = 1'b0;
      vram_base = 7'h33;
      push_copy(7'h33, 0, 0);
      vb_pulse();
      rd(10'd7, vdata({7'h2A, 10'd7}));
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("stalled cs", {31'd0, vif.vram_cs}, 32'd1);
      push_copy(7'h33, 0, 0);
      vb_pulse();
      @(negedge clk);
      check("overrun set", {31'd0, copy_overrun}, 32'd1);
      check("busy after abort", {31'd0, busy}, 32'd1);
      rd(10'd7, vdata({7'h2A, 10'd7}));
      push_copy(7'h33, 1, 1023);
      ok_en = 1'b1;
      wait_idle("copy3");
      check("overrun sticky", {31'd0, copy_overrun}, 32'd1);
      vram_base = 7'h40;
      push_copy(7'h40, 0, 1023);
      vb_pulse();
      @(negedge clk);
      check("overrun cleared by swap", {31'd0, copy_overrun}, 32'd0);
      rd(10'd9, vdata({7'h33, 10'd9}));
      wait_idle("copy4");

      // Reset during WAIT
      ok_en = 1'b0;
      push_copy(7'h40, 0, 0);
      vb_pulse();
      while (cyc % 128 != 10) @(posedge clk);
      @(negedge clk);
      check("cs before rst", {31'd0, vif.vram_cs}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst cs async", {31'd0, vif.vram_cs}, 32'd0);
      check("rst busy async", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      check("line_start in rst", {31'd0, line_start}, 32'd0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      ok_en = 1'b1;
      check("no requests left", aq.size(), 32'd0);
      rd(10'd3, vdata({7'h40, 10'd3}));

`ifdef JTCPS1_OBJ_ENDMARK_EN
      endmark_on = 1'b1;
      push_copy(7'h40, 0, 11);
`else
      push_copy(7'h40, 0, 1023);
`endif
      vb_pulse();
      rd(10'd3, vdata({7'h40, 10'd3}));
      wait_idle("copy6");
      endmark_on = 1'b0;

      push_copy(7'h40, 0, 1023);
      vb_pulse();
`ifdef JTCPS1_OBJ_ENDMARK_EN
      rd(10'd11, 16'hFF00);
      rd(10'd12, 16'hFFFF);
      rd(10'd1023, 16'hFFFF);
`else
      rd(10'd11, vdata({7'h40, 10'd11}));
      rd(10'd12, vdata({7'h40, 10'd12}));
      rd(10'd1023, vdata({7'h40, 10'd1023}));
`endif
      wait_idle("copy7");

      hs_run = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("line_start all seen", lq.size(), 32'd0);
      check("frame reads all seen", rq.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
